axi_sram_slave: RTL and testbench

AXI3-style slave that terminates bursts issued by the core's SRAM-bus-to-AXI master and drives a single-port synchronous SRAM (1-cycle read latency). Sits behind the AXI interconnect as the memory slave (address regions 0x0/0x1). It serves one transaction at a time and arbitrates between write and read round-robin. INCR and FIXED bursts of 1–16 beats are supported.

---
 rtl/axi_sram_slave.sv | 132 +++++++++++++
 tb/tb_axi_sram_slave.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 burst slave serving one transaction at a time onto a
// single-port synchronous SRAM, with round-robin write/read arbitration.
module axi_sram_slave #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int ID_WIDTH   = 7,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int MEM_AW     = 12
) (
   input  logic                  ACLK,
   input  logic                  ARESETn,
   input  logic [ADDR_WIDTH-1:0] AWADDR,
   input  logic [3:0]            AWLEN,
   input  logic [2:0]            AWSIZE,
   input  logic [1:0]            AWBURST,
   input  logic [ID_WIDTH-1:0]   AWID,
   input  logic                  AWVALID,
   output logic                  AWREADY,
   input  logic [DATA_WIDTH-1:0] WDATA,
   input  logic [STRB_WIDTH-1:0] WSTRB,
   input  logic                  WLAST,
   input  logic [ID_WIDTH-1:0]   WID,
   input  logic                  WVALID,
   output logic                  WREADY,
   output logic [1:0]            BRESP,
   output logic [ID_WIDTH-1:0]   BID,
   output logic                  BVALID,
   input  logic                  BREADY,
   input  logic [ADDR_WIDTH-1:0] ARADDR,
   input  logic [3:0]            ARLEN,
   input  logic [2:0]            ARSIZE,
   input  logic [1:0]            ARBURST,
   input  logic [ID_WIDTH-1:0]   ARID,
   input  logic                  ARVALID,
   output logic                  ARREADY,
   output logic [DATA_WIDTH-1:0] RDATA,
   output logic [1:0]            RRESP,
   output logic                  RLAST,
   output logic [ID_WIDTH-1:0]   RID,
   output logic                  RVALID,
   input  logic                  RREADY,
   output logic                  sram_en,
   output logic [STRB_WIDTH-1:0] sram_we,
   output logic [MEM_AW-1:0]     sram_addr,
   output logic [DATA_WIDTH-1:0] sram_wdata,
   input  logic [DATA_WIDTH-1:0] sram_rdata
);
   localparam int LB = $clog2(STRB_WIDTH);
   typedef enum logic [2:0] {S_IDLE, S_WDATA, S_WRESP, S_RREQ, S_RWAIT, S_RDATA} state_t;
   state_t state, state_nx;
   logic rr, err, wl_err, aw_go, ar_go, w_go, r_go, last;
   logic [ADDR_WIDTH-1:0] addr, step;
   logic [3:0] len, cnt;
   logic [2:0] size, sz;
   logic [1:0] burst, bst;
   logic [ID_WIDTH-1:0] id;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic unused_ok;
   // Readies are held low while reset is asserted so nothing looks accepted.
   assign aw_go = state == S_IDLE && ARESETn && AWVALID && (!ARVALID || !rr);
   assign ar_go = state == S_IDLE && ARESETn && ARVALID && !aw_go;
   assign w_go = state == S_WDATA && WVALID;
   assign r_go = state == S_RDATA && RREADY;
   assign last = cnt == len;
   assign sz = aw_go ? AWSIZE : ARSIZE;
   assign bst = aw_go ? AWBURST : ARBURST;
   assign step = burst == 2'b01 ? {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size : '0;
   assign sram_addr = addr[MEM_AW+LB-1:LB];
   assign BRESP = {err | wl_err, 1'b0};
   assign RRESP = {err, 1'b0};
   assign BID = id;
   assign RID = id;
   assign RDATA = rdata_q;
   assign unused_ok = ^{WID, addr[ADDR_WIDTH-1:MEM_AW+LB], addr[LB-1:0]};
   always_comb begin
      state_nx = state;
      AWREADY = aw_go;
      ARREADY = ar_go;
      WREADY = state == S_WDATA;
      BVALID = state == S_WRESP;
      RVALID = state == S_RDATA;
      RLAST = state == S_RDATA && last;
      sram_en = w_go || state == S_RREQ;
      sram_we = (w_go && !err) ? WSTRB : '0;
      sram_wdata = w_go ? WDATA : '0;
      case (state)
         S_IDLE:  state_nx = aw_go ? S_WDATA : ar_go ? S_RREQ : S_IDLE;
         S_WDATA: state_nx = (w_go && last) ? S_WRESP : S_WDATA;
         S_WRESP: state_nx = BREADY ? S_IDLE : S_WRESP;
         S_RREQ:  state_nx = S_RWAIT;
         S_RWAIT: state_nx = S_RDATA;
         S_RDATA: state_nx = r_go ? (last ? S_IDLE : S_RREQ) : S_RDATA;
         default: state_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge ACLK or negedge ARESETn) begin
      if (!ARESETn) begin
         state <= S_IDLE;
         rr <= 1'b0;
         addr <= '0;
         len <= '0;
         size <= '0;
         burst <= '0;
         id <= '0;
         cnt <= '0;
         err <= 1'b0;
         wl_err <= 1'b0;
         rdata_q <= '0;
      end else begin
         state <= state_nx;
         if (aw_go || ar_go) begin
            addr <= aw_go ? AWADDR : ARADDR;
            len <= aw_go ? AWLEN : ARLEN;
            id <= aw_go ? AWID : ARID;
            size <= sz;
            burst <= bst;
            cnt <= '0;
            err <= bst[1] || int'(sz) > LB;
            wl_err <= 1'b0;
         end
         if (w_go || r_go) begin
            cnt <= cnt + 4'd1;
            addr <= addr + step;
         end
         // The beat counter ends the burst; a misplaced WLAST only taints BRESP.
         if (w_go && WLAST != last) wl_err <= 1'b1;
         if (state == S_WRESP && BREADY) rr <= 1'b1;
         if (r_go && last) rr <= 1'b0;
         if (state == S_RWAIT) rdata_q <= err ? '0 : sram_rdata;
      end
   end
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed and randomized bursts checked against a
// word-array reference model of the SRAM contents and address arithmetic.
module tb_axi_sram_slave;
   logic ACLK = 1'b0, ARESETn = 1'b0;
   logic [31:0] AWADDR, ARADDR, WDATA, RDATA, sram_wdata, sram_rdata;
   logic [3:0] AWLEN, ARLEN, WSTRB, sram_we;
   logic [2:0] AWSIZE, ARSIZE;
   logic [1:0] AWBURST, ARBURST, BRESP, RRESP;
   logic [6:0] AWID, ARID, WID, BID, RID;
   logic AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
   logic ARVALID, ARREADY, RLAST, RVALID, RREADY, sram_en;
   logic [11:0] sram_addr;
   logic [31:0] mem [0:4095];
   logic [31:0] ref_mem [0:4095];
   int n_checks = 0, n_fail = 0;

   axi_sram_slave dut (
      .ACLK(ACLK), .ARESETn(ARESETn),
      .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWID(AWID),
      .AWVALID(AWVALID), .AWREADY(AWREADY),
      .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WID(WID), .WVALID(WVALID), .WREADY(WREADY),
      .BRESP(BRESP), .BID(BID), .BVALID(BVALID), .BREADY(BREADY),
      .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID),
      .ARVALID(ARVALID), .ARREADY(ARREADY),
      .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RID(RID), .RVALID(RVALID), .RREADY(RREADY),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   always #5 ACLK = ~ACLK;

   always @(posedge ACLK) begin
      if (sram_en) begin
         for (int b = 0; b < 4; b++)
            if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
         sram_rdata <= mem[sram_addr];
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] waddr(input logic [31:0] a);
      return a[13:2];
   endfunction

   function automatic bit is_err(input logic [1:0] burst, input logic [2:0] size);
      return burst > 2'd1 || size > 3'd2;
   endfunction

   task automatic write_tx(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [6:0] id, input bit both,
                           input int bad_last, input bit use_d, input logic [31:0] d0,
                           input logic [3:0] s0);
      logic [31:0] cur = a;
      bit err = is_err(burst, size);
      int n = 0;
      int bw = $urandom_range(0, 2);
      @(negedge ACLK);
      AWADDR = a; AWLEN = len; AWSIZE = size; AWBURST = burst; AWID = id; AWVALID = 1'b1;
      if (both) begin
         ARADDR = $urandom; ARLEN = 4'd0; ARSIZE = 3'd2; ARBURST = 2'b01; ARID = 7'h7F; ARVALID = 1'b1;
      end
      #1;
      while (!AWREADY && n < 20) begin
         @(negedge ACLK); #1; n++;
      end
      if (both) check("arb_ar_lost", 64'(ARREADY), 64'd0);
      check("aw_ready", 64'(AWREADY), 64'd1);
      for (int i = 0; i <= int'(len); i++) begin
         @(negedge ACLK);
         AWVALID = 1'b0; ARVALID = 1'b0; WVALID = 1'b1; WID = id;
         WDATA = use_d ? d0 : $urandom;
         WSTRB = use_d ? s0 : 4'($urandom_range(0, 15));
         WLAST = (i == int'(len)) ^ (i == bad_last);
         #1;
         check("w_ready", 64'(WREADY), 64'd1);
         check("w_sram_en", 64'(sram_en), 64'd1);
         check("w_sram_addr", 64'(sram_addr), 64'(waddr(cur)));
         check("w_sram_we", 64'(sram_we), err ? 64'd0 : 64'(WSTRB));
         check("w_sram_wdata", 64'(sram_wdata), 64'(WDATA));
         if (!err)
            for (int b = 0; b < 4; b++)
               if (WSTRB[b]) ref_mem[waddr(cur)][8*b +: 8] = WDATA[8*b +: 8];
         if (burst == 2'b01) cur = cur + (32'd1 << size);
      end
      @(negedge ACLK);
      WVALID = 1'b0; WLAST = 1'b0;
      #1;
      check("b_valid", 64'(BVALID), 64'd1);
      check("b_id", 64'(BID), 64'(id));
      check("b_resp", 64'(BRESP), (err || bad_last >= 0) ? 64'd2 : 64'd0);
      check("w_ready_off", 64'(WREADY), 64'd0);
      repeat (bw) begin
         @(negedge ACLK); #1;
         check("b_held", 64'(BVALID), 64'd1);
      end
      BREADY = 1'b1;
      @(posedge ACLK); #1;
      BREADY = 1'b0;
      check("b_drop", 64'(BVALID), 64'd0);
   endtask

   task automatic read_tx(input logic [31:0] a, input logic [3:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [6:0] id, input bit both,
                          input int stall_beat, input int stall_n);
      logic [31:0] cur = a;
      logic [31:0] exp;
      bit err = is_err(burst, size);
      int n = 0;
      @(negedge ACLK);
      ARADDR = a; ARLEN = len; ARSIZE = size; ARBURST = burst; ARID = id; ARVALID = 1'b1;
      if (both) begin
         AWADDR = $urandom; AWLEN = 4'd0; AWSIZE = 3'd2; AWBURST = 2'b01; AWID = 7'h7E; AWVALID = 1'b1;
      end
      #1;
      while (!ARREADY && n < 20) begin
         @(negedge ACLK); #1; n++;
      end
      if (both) check("arb_aw_lost", 64'(AWREADY), 64'd0);
      check("ar_ready", 64'(ARREADY), 64'd1);
      @(posedge ACLK);
      for (int i = 0; i <= int'(len); i++) begin
         @(negedge ACLK);
         ARVALID = 1'b0; AWVALID = 1'b0;
         #1;
         check("r_sram_en", 64'(sram_en), 64'd1);
         check("r_sram_we", 64'(sram_we), 64'd0);
         check("r_sram_addr", 64'(sram_addr), 64'(waddr(cur)));
         check("r_early", 64'(RVALID), 64'd0);
         @(negedge ACLK); #1;
         check("r_wait", 64'(RVALID), 64'd0);
         @(negedge ACLK); #1;
         exp = err ? 32'd0 : ref_mem[waddr(cur)];
         check("r_valid", 64'(RVALID), 64'd1);
         check("r_data", 64'(RDATA), 64'(exp));
         check("r_resp", 64'(RRESP), err ? 64'd2 : 64'd0);
         check("r_last", 64'(RLAST), 64'(i == int'(len)));
         check("r_id", 64'(RID), 64'(id));
         if (i == stall_beat)
            repeat (stall_n) begin
               @(negedge ACLK); #1;
               check("r_stall_valid", 64'(RVALID), 64'd1);
               check("r_stall_data", 64'(RDATA), 64'(exp));
               check("r_stall_last", 64'(RLAST), 64'(i == int'(len)));
            end
         RREADY = 1'b1;
         @(posedge ACLK); #1;
         RREADY = 1'b0;
         if (burst == 2'b01) cur = cur + (32'd1 << size);
      end
      check("r_done", 64'(RVALID), 64'd0);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      logic [3:0] len;
      logic [2:0] size;
      logic [1:0] burst;
      for (int i = 0; i < 4096; i++) begin
         mem[i] = 32'd0;
         ref_mem[i] = 32'd0;
      end
      {AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWVALID} = '0;
      {WDATA, WSTRB, WLAST, WID, WVALID, BREADY} = '0;
      {ARADDR, ARLEN, ARSIZE, ARBURST, ARID, ARVALID, RREADY} = '0;
      sram_rdata = 32'd0;
      repeat (2) @(negedge ACLK);
      #1;
      check("rst_outputs", 64'({AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST, sram_en}), 64'd0);
      check("rst_we_resp", 64'({sram_we, BRESP, RRESP}), 64'd0);
      check("rst_rdata", 64'(RDATA), 64'd0);
      check("rst_ids", 64'({BID, RID}), 64'd0);
      check("rst_addr_wdata", 64'({sram_addr, sram_wdata}), 64'd0);
      @(negedge ACLK);
      ARESETn = 1'b1;

      // Simultaneous requests: write wins first, then read on the next tie.
      write_tx(32'h10, 4'd0, 3'd2, 2'b01, 7'h11, 1'b1, -1, 1'b1, 32'hAABBCCDD, 4'b0101);
      read_tx(32'h10, 4'd0, 3'd2, 2'b01, 7'h22, 1'b1, -1, 0);
      check("single_write_word", 64'(ref_mem[4]), 64'h00BB00DD);

      write_tx(32'h100, 4'd3, 3'd2, 2'b01, 7'h05, 1'b0, -1, 1'b0, 32'd0, 4'd0);
      read_tx(32'h100, 4'd3, 3'd2, 2'b01, 7'h06, 1'b0, -1, 0);

      write_tx(32'h20, 4'd0, 3'd2, 2'b01, 7'h01, 1'b0, -1, 1'b1, 32'h12345678, 4'hF);
      read_tx(32'h20, 4'd2, 3'd2, 2'b00, 7'h33, 1'b0, 0, 5);

      write_tx(32'h40, 4'd1, 3'd2, 2'b10, 7'h44, 1'b0, -1, 1'b0, 32'd0, 4'd0);
      read_tx(32'h10, 4'd0, 3'd3, 2'b01, 7'h45, 1'b0, -1, 0);

      write_tx(32'h60, 4'd2, 3'd2, 2'b01, 7'h50, 1'b0, 1, 1'b0, 32'd0, 4'd0);
      write_tx(32'h70, 4'd2, 3'd2, 2'b01, 7'h51, 1'b0, 2, 1'b0, 32'd0, 4'd0);
      read_tx(32'h60, 4'd2, 3'd2, 2'b01, 7'h52, 1'b0, -1, 0);

      write_tx(32'hFFFF_3FF8, 4'd3, 3'd2, 2'b01, 7'h60, 1'b0, -1, 1'b0, 32'd0, 4'd0);
      read_tx(32'h0000_3FF8, 4'd3, 3'd2, 2'b01, 7'h61, 1'b0, 1, 2);

      // Reset during beat 2 of a 4-beat write.
      @(negedge ACLK);
      AWADDR = 32'h200; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'b01; AWID = 7'h70; AWVALID = 1'b1;
      #1;
      check("rst_aw_ready", 64'(AWREADY), 64'd1);
      @(negedge ACLK);
      AWVALID = 1'b0; WVALID = 1'b1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WLAST = 1'b0;
      #1;
      check("rst_beat1_en", 64'(sram_en), 64'd1);
      ref_mem[12'h080] = 32'hCAFEF00D;
      @(negedge ACLK);
      WDATA = 32'hDEADBEEF;
      #1;
      check("rst_beat2_en", 64'(sram_en), 64'd1);
      ARESETn = 1'b0;
      #1;
      check("rst_mid_en", 64'(sram_en), 64'd0);
      check("rst_mid_wready", 64'(WREADY), 64'd0);
      @(negedge ACLK);
      WVALID = 1'b0;
      @(negedge ACLK);
      ARESETn = 1'b1;
      @(negedge ACLK); #1;
      check("rst_after_wready", 64'(WREADY), 64'd0);
      check("rst_after_en", 64'(sram_en), 64'd0);
      write_tx(32'h300, 4'd0, 3'd2, 2'b01, 7'h71, 1'b0, -1, 1'b0, 32'd0, 4'd0);
      read_tx(32'h200, 4'd1, 3'd2, 2'b01, 7'h72, 1'b0, -1, 0);

      for (int t = 0; t < 30; t++) begin
         a = $urandom & 32'hFFFF_C1FF;
         len = 4'($urandom_range(0, 15));
         size = $urandom_range(0, 9) < 9 ? 3'($urandom_range(0, 2)) : 3'd3;
         burst = $urandom_range(0, 9) == 0 ? 2'b11 : 2'($urandom_range(0, 1));
         d = $urandom;
         if ($urandom_range(0, 1) == 1)
            write_tx(a, len, size, burst, d[6:0], 1'b0, -1, 1'b0, 32'd0, 4'd0);
         else
            read_tx(a, len, size, burst, d[6:0], 1'b0, $urandom_range(0, 15), $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
